mem_responder: RTL and testbench
================================

Name: mem_responder

Overview:
- Responder end of the ctrl_unit line-memory protocol: accepts `read_request_valid` / `write_request_valid` with a 32-bit line address.
- Acknowledges each accepted request with `buffer_addr_valid`, then completes it with `data_valid` plus `read_data` (reads) or `write_done` (writes), after fixed programmable latencies.
- Backs requests with an on-chip 512-bit line RAM, preloadable via a host port.
- Used as the memory model for control-path bring-up and as the on-FPGA line buffer.

Parameters:
- DEPTH, 4096, number of 512-bit lines in the RAM (power of two).
- READ_LATENCY, 4, cycles from `buffer_addr_valid` to `data_valid` (legal range 1..15).
- WRITE_LATENCY, 2, cycles from `buffer_addr_valid` to `write_done` (legal range 1..15).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- address  in  32  line address of the request
- write_data  in  512  write line
- read_request_valid  in  1  read request, held by the initiator until acknowledged
- write_request_valid  in  1  write request, held by the initiator until acknowledged
- buffer_addr_valid  out  1  one-cycle acceptance pulse
- data_valid  out  1  one-cycle read completion pulse
- read_data  out  512  read line, valid while `data_valid` is high
- write_done  out  1  one-cycle write completion pulse
- host_wr_en  in  1  host preload write strobe
- host_wr_addr  in  $clog2(DEPTH)  host preload line address
- host_wr_data  in  512  host preload line

Behaviour:
- Single clock `clk`; reset `rst_n` is asynchronous, active-low.
- All outputs are registered.
- Reset values: `buffer_addr_valid`, `data_valid` and `write_done` = 0; `read_data` = 0; state IDLE; latency counter = 0.
- RAM contents are not reset.

State machine:
- IDLE -> RD_WAIT / WR_WAIT on acceptance.
- RD_WAIT -> RD_RESP when the counter reaches 0.
- WR_WAIT -> WR_RESP when the counter reaches 0.
- RD_RESP / WR_RESP -> IDLE after one cycle.

Acceptance:
- Requests are sampled only in IDLE.
- Both valids high in the same cycle: the read is accepted, and the write stays pending. The initiator keeps holding it, so it is accepted on the next IDLE cycle.
- On acceptance in cycle T, `address` (and `write_data` for writes) is captured.
- `buffer_addr_valid` is high in cycle T+1 only.
- The counter loads the programmed latency minus 1.

Completion timing:
- Read: `data_valid` is high in cycle T+1+READ_LATENCY, with `read_data` = RAM[addr].
- Write: the RAM write commits on the edge ending cycle T+WRITE_LATENCY; `write_done` is high in cycle T+1+WRITE_LATENCY.
- Next request accepted no earlier than cycle T+2+latency.
- Request valids held during busy states are ignored. An initiator must drop its valid after seeing `buffer_addr_valid`.

`read_data` and address handling:
- `read_data` holds its last value between `data_valid` pulses.
- Address indexing uses `address[$clog2(DEPTH)-1:0]`.
- Upper bits at or beyond DEPTH: wrap-around (see Optional Feature for the error variant).

Host port:
- `host_wr_en` writes RAM in any cycle.
- If it collides with a request write commit to the same line in the same cycle, the request write wins.
- A read whose RAM access coincides with a host write to the same line returns the old data (read-before-write).

Reset mid-operation:
- Aborts immediately, with no pending pulses after release.
- An uncommitted write is dropped.

Optional Feature:
- Macro: MEM_RESP_RANGE_CHECK_EN.
- Defined:
  - Adds output `range_err` (1 bit) and output `err_count` (16 bits, saturating). Both reset to 0.
  - Any accepted request with `address` >= DEPTH sets `range_err` sticky and increments `err_count`.
  - Such a read returns all-zero `read_data`; such a write does not modify the RAM.
  - The handshake pulses occur exactly as normal.
- Undefined: no extra ports; addresses wrap modulo DEPTH.

Decomposition:
- Package mem_resp_pkg:
  - LINE_W = 512 and the line typedef.
  - State enum {IDLE, RD_WAIT, WR_WAIT, RD_RESP, WR_RESP}.
  - Latency counter width = 4.
- Sub-module mem_resp_line_ram:
  - One synchronous read port, one request write port, one host write port.
  - Request write has priority on collision.
  - Read-before-write.
- mem_responder holds the FSM, capture registers and the optional range logic.

Test Plan:
- Host preload line 5 = {64{8'hA5}}; read request addr=5 at cycle T -> `buffer_addr_valid` at T+1, `data_valid` at T+5 with `read_data` = {64{8'hA5}}, no other pulses.
- Write addr=7, data = 512'h1234 at T -> `buffer_addr_valid` T+1, `write_done` T+3; subsequent read of 7 returns 512'h1234.
- Read and write both requested at T (addrs 1 and 2) -> read acknowledged T+1, `data_valid` T+5; write acknowledged T+7, `write_done` T+9.
- Back-to-back: initiator re-asserts read immediately after each `data_valid`, 8 reads -> exactly 8 acks and 8 `data_valid` pulses, spacing 6 cycles.
- Assert `rst_n` = 0 at T+2 of a read -> `data_valid` never pulses; after release, IDLE accepts a new request normally.
- With MEM_RESP_RANGE_CHECK_EN, read addr = DEPTH+3 -> normal pulses, `read_data` = 0, `range_err` = 1, `err_count` = 1. Without the macro, the same request returns RAM[3].

Source files
------------

// File: rtl/mem_resp_pkg.sv
// Shared types for the line-memory responder: line width, FSM states and counter sizing.
package mem_resp_pkg;

  localparam int unsigned LINE_W = 512;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned ERR_W  = 16;

  typedef logic [LINE_W-1:0] line_t;

  typedef enum logic [2:0] {
    IDLE,
    RD_WAIT,
    WR_WAIT,
    RD_RESP,
    WR_RESP
  } state_e;

  // Counter load value for a programmed latency of 1..15 cycles.
  function automatic logic [CNT_W-1:0] lat_load(input int unsigned lat);
    return CNT_W'(lat - 1);
  endfunction

endpackage

// File: rtl/mem_resp_line_ram.sv
// Line RAM: one synchronous read port with a reset output register, a request write port
// and a host write port. The request write wins on a same-line collision; reads see old data.
module mem_resp_line_ram
  import mem_resp_pkg::*;
#(
  parameter int unsigned DEPTH = 4096
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     rd_en,
  input  logic                     rd_zero,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output line_t                    rd_data,
  input  logic                     req_wr_en,
  input  logic [$clog2(DEPTH)-1:0] req_wr_addr,
  input  line_t                    req_wr_data,
  input  logic                     host_wr_en,
  input  logic [$clog2(DEPTH)-1:0] host_wr_addr,
  input  line_t                    host_wr_data
);

  line_t mem [DEPTH];
  line_t rd_data_q, rd_data_d;
  logic  host_blocked_c;

  assign host_blocked_c = req_wr_en && (req_wr_addr == host_wr_addr);

  always_ff @(posedge clk) begin
    if (host_wr_en && !host_blocked_c) mem[host_wr_addr] <= host_wr_data;
    if (req_wr_en) mem[req_wr_addr] <= req_wr_data;
  end

  // Output register holds the last line between reads.
  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) rd_data_d = rd_zero ? '0 : mem[rd_addr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_data_q <= '0;
    else        rd_data_q <= rd_data_d;
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/mem_responder.sv
// Responder end of the ctrl_unit line-memory protocol, backed by an on-chip line RAM.
// Optional out-of-range detection is enabled with `define MEM_RESP_RANGE_CHECK_EN.
module mem_responder
  import mem_resp_pkg::*;
#(
  parameter int unsigned DEPTH         = 4096,
  parameter int unsigned READ_LATENCY  = 4,
  parameter int unsigned WRITE_LATENCY = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [ADDR_W-1:0]        address,
  input  line_t                    write_data,
  input  logic                     read_request_valid,
  input  logic                     write_request_valid,
  output logic                     buffer_addr_valid,
  output logic                     data_valid,
  output line_t                    read_data,
  output logic                     write_done,
  input  logic                     host_wr_en,
  input  logic [$clog2(DEPTH)-1:0] host_wr_addr,
  input  line_t                    host_wr_data
`ifdef MEM_RESP_RANGE_CHECK_EN
  ,
  output logic                     range_err,
  output logic [ERR_W-1:0]         err_count
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [AW-1:0]     addr_q, addr_d;
  line_t             wdata_q, wdata_d;
  logic              buffer_addr_valid_q, buffer_addr_valid_d;
  logic              data_valid_q, data_valid_d;
  logic              write_done_q, write_done_d;
  logic              accept_c, req_oor_c, ram_rd_en_c, ram_wr_en_c;

  assign accept_c = (state_q == IDLE) && (read_request_valid || write_request_valid);

  // Next-state and pulse logic; reads take priority when both valids arrive together.
  always_comb begin
    state_d             = state_q;
    cnt_d               = cnt_q;
    addr_d              = addr_q;
    wdata_d             = wdata_q;
    buffer_addr_valid_d = 1'b0;
    data_valid_d        = 1'b0;
    write_done_d        = 1'b0;
    ram_rd_en_c         = 1'b0;
    ram_wr_en_c         = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept_c) begin
          buffer_addr_valid_d = 1'b1;
          addr_d              = address[AW-1:0];
          wdata_d             = write_data;
          if (read_request_valid) begin
            state_d = RD_WAIT;
            cnt_d   = lat_load(READ_LATENCY);
          end else begin
            state_d = WR_WAIT;
            cnt_d   = lat_load(WRITE_LATENCY);
          end
        end
      end
      RD_WAIT: begin
        if (cnt_q == '0) begin
          state_d      = RD_RESP;
          data_valid_d = 1'b1;
          ram_rd_en_c  = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      WR_WAIT: begin
        if (cnt_q == '0) begin
          state_d      = WR_RESP;
          write_done_d = 1'b1;
          ram_wr_en_c  = !req_oor_c;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RD_RESP, WR_RESP: state_d = IDLE;
      default:          state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q             <= IDLE;
      cnt_q               <= '0;
      addr_q              <= '0;
      wdata_q             <= '0;
      buffer_addr_valid_q <= 1'b0;
      data_valid_q        <= 1'b0;
      write_done_q        <= 1'b0;
    end else begin
      state_q             <= state_d;
      cnt_q               <= cnt_d;
      addr_q              <= addr_d;
      wdata_q             <= wdata_d;
      buffer_addr_valid_q <= buffer_addr_valid_d;
      data_valid_q        <= data_valid_d;
      write_done_q        <= write_done_d;
    end
  end

`ifdef MEM_RESP_RANGE_CHECK_EN
  logic              oor_q, oor_d, new_oor_c;
  logic              range_err_q, range_err_d;
  logic [ERR_W-1:0]  err_count_q, err_count_d;

  assign new_oor_c = (address >= ADDR_W'(DEPTH));

  // Flag the captured request and keep a sticky, saturating error tally.
  always_comb begin
    oor_d       = oor_q;
    range_err_d = range_err_q;
    err_count_d = err_count_q;
    if (accept_c) begin
      oor_d = new_oor_c;
      if (new_oor_c) begin
        range_err_d = 1'b1;
        if (err_count_q != '1) err_count_d = err_count_q + ERR_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      oor_q       <= 1'b0;
      range_err_q <= 1'b0;
      err_count_q <= '0;
    end else begin
      oor_q       <= oor_d;
      range_err_q <= range_err_d;
      err_count_q <= err_count_d;
    end
  end

  assign req_oor_c = oor_q;
  assign range_err = range_err_q;
  assign err_count = err_count_q;
`else
  logic unused_addr_hi_c;
  assign unused_addr_hi_c = ^address[ADDR_W-1:AW];
  assign req_oor_c        = 1'b0;
`endif

  mem_resp_line_ram #(.DEPTH(DEPTH)) u_ram (
    .clk          (clk),
    .rst_n        (rst_n),
    .rd_en        (ram_rd_en_c),
    .rd_zero      (req_oor_c),
    .rd_addr      (addr_q),
    .rd_data      (read_data),
    .req_wr_en    (ram_wr_en_c),
    .req_wr_addr  (addr_q),
    .req_wr_data  (wdata_q),
    .host_wr_en   (host_wr_en),
    .host_wr_addr (host_wr_addr),
    .host_wr_data (host_wr_data)
  );

  assign buffer_addr_valid = buffer_addr_valid_q;
  assign data_valid        = data_valid_q;
  assign write_done        = write_done_q;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: directed table, multi-cycle corner sequences and random traffic
// against a transaction-level memory model. Honours `define MEM_RESP_RANGE_CHECK_EN.
module tb_mem_responder;
  import mem_resp_pkg::*;

  localparam int unsigned DEPTH = 4096;
  localparam int unsigned AW    = 12;
  localparam int          RL    = 4;
  localparam int          WL    = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [31:0]   address;
  line_t         write_data;
  logic          read_request_valid, write_request_valid;
  logic          buffer_addr_valid, data_valid, write_done;
  line_t         read_data;
  logic          host_wr_en;
  logic [AW-1:0] host_wr_addr;
  line_t         host_wr_data;
`ifdef MEM_RESP_RANGE_CHECK_EN
  logic          range_err;
  logic [15:0]   err_count;
`endif

  mem_responder #(.DEPTH(DEPTH), .READ_LATENCY(RL), .WRITE_LATENCY(WL)) dut (
    .clk(clk), .rst_n(rst_n), .address(address), .write_data(write_data),
    .read_request_valid(read_request_valid), .write_request_valid(write_request_valid),
    .buffer_addr_valid(buffer_addr_valid), .data_valid(data_valid), .read_data(read_data),
    .write_done(write_done), .host_wr_en(host_wr_en), .host_wr_addr(host_wr_addr),
    .host_wr_data(host_wr_data)
`ifdef MEM_RESP_RANGE_CHECK_EN
    , .range_err(range_err), .err_count(err_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_wr;
    logic [31:0] addr;
    line_t       wdata;
    line_t       exp;
  } vec_t;

  vec_t       tbl [8];
  line_t      mem_m [int];
  line_t      last_rd, got, w, exp1, old_l, new_l, a_l, b_l;
  int         chk_cnt, pass_cnt, ack_cnt, dv_cnt, wd_cnt, err_m, a0, d0;
  bit         rerr_m, in_resp;
  longint     cyc, last_done_cyc, prev_done;

  task automatic check_bits(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic check_line(input string name, input line_t act, input line_t exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [2:0] pulses();
    return {buffer_addr_valid, data_valid, write_done};
  endfunction

  function automatic line_t rnd_line();
    line_t r;
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic bit is_oor(input logic [31:0] a);
`ifdef MEM_RESP_RANGE_CHECK_EN
    return a >= DEPTH;
`else
    return 1'b0;
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (buffer_addr_valid) ack_cnt++;
    if (data_valid) dv_cnt++;
    if (write_done) wd_cnt++;
  endtask

  task automatic host_set(input bit en, input int idx, input line_t d);
    host_wr_en   = en;
    host_wr_addr = idx[AW-1:0];
    host_wr_data = d;
  endtask

  task automatic host_rand();
    if ($urandom_range(2) == 0) host_set(1'b1, int'($urandom_range(15)), rnd_line());
    else host_set(1'b0, 0, '0);
  endtask

  // Model side of a host write that went out on the edge just taken.
  task automatic host_commit();
    if (host_wr_en) mem_m[int'(host_wr_addr)] = host_wr_data;
    host_wr_en = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      host_set(1'b0, 0, '0);
      step();
      check_bits("idle_quiet", 32'(pulses()), 0);
    end
    in_resp = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    last_rd = '0; rerr_m = 1'b0; err_m = 0; in_resp = 1'b0;
  endtask

  // One request seen by a well-behaved initiator. hmode: 0 none, 1 random host traffic,
  // 2 host write of hd to the same line in the cycle the request touches the RAM.
  task automatic run_txn(input bit is_wr, input logic [31:0] a, input line_t wd,
                         input int hmode, input line_t hd, output line_t rd);
    int    lat, idx;
    bit    oor;
    line_t exp;
    lat = is_wr ? WL : RL;
    idx = int'(a % DEPTH);
    oor = is_oor(a);
    exp = last_rd;
    address = a; write_data = wd;
    read_request_valid = !is_wr; write_request_valid = is_wr;
    if (in_resp) begin
      if (hmode == 1) host_rand(); else host_set(1'b0, 0, '0);
      step(); host_commit();
      check_bits("busy_ignored", 32'(pulses()), 0);
    end
    in_resp = 1'b0;
    if (hmode == 1) host_rand(); else host_set(1'b0, 0, '0);
    step(); host_commit();
    check_bits("ack", 32'(pulses()), 32'b100);
`ifdef MEM_RESP_RANGE_CHECK_EN
    if (oor) begin rerr_m = 1'b1; if (err_m < 65535) err_m++; end
    check_bits("range_err", 32'(range_err), 32'(rerr_m));
    check_bits("err_count", 32'(err_count), 32'(err_m));
`endif
    read_request_valid = 1'b0; write_request_valid = 1'b0;
    address = $urandom; write_data = rnd_line();
    for (int k = 1; k <= lat; k++) begin
      if (hmode == 1) host_rand();
      else if (hmode == 2 && k == lat) host_set(1'b1, idx, hd);
      else host_set(1'b0, 0, '0);
      if (!is_wr && k == lat) exp = oor ? '0 : mem_m[idx];
      step(); host_commit();
      if (is_wr && k == lat && !oor) mem_m[idx] = wd;
      if (k < lat) begin
        check_bits("wait_quiet", 32'(pulses()), 0);
        check_line("rd_hold", read_data, last_rd);
      end else begin
        check_bits("complete", 32'(pulses()), is_wr ? 32'b001 : 32'b010);
        if (!is_wr) begin
          check_line("rd_data", read_data, exp);
          last_rd = exp;
        end
      end
    end
    rd = read_data;
    in_resp = 1'b1;
    last_done_cyc = cyc;
  endtask

  initial begin
    chk_cnt = 0; pass_cnt = 0; ack_cnt = 0; dv_cnt = 0; wd_cnt = 0; cyc = 0;
    address = '0; write_data = '0; read_request_valid = 1'b0; write_request_valid = 1'b0;
    host_set(1'b0, 0, '0);
    do_reset();
    step(); step();
    check_bits("rst_pulses", 32'(pulses()), 0);
    check_line("rst_rdata", read_data, '0);
`ifdef MEM_RESP_RANGE_CHECK_EN
    check_bits("rst_range", {15'd0, range_err, err_count}, 0);
`endif
    rst_n = 1'b1;
    step();

    // Preload lines 0..15; line 5 carries the A5 pattern.
    for (int i = 0; i < 16; i++) begin
      host_set(1'b1, i, (i == 5) ? {64{8'hA5}} : rnd_line());
      step(); host_commit();
    end
    idle(1);

    tbl[0] = '{1'b1, 32'd7, 512'h1234, '0};
    tbl[1] = '{1'b0, 32'd7, '0, 512'h1234};
    tbl[2] = '{1'b0, 32'd5, '0, {64{8'hA5}}};
    tbl[3] = '{1'b1, 32'd9, '1, '0};
    tbl[4] = '{1'b0, 32'd9, '0, '1};
    tbl[5] = '{1'b1, 32'd7, {16{32'hDEADBEEF}}, '0};
    tbl[6] = '{1'b0, 32'd7, '0, {16{32'hDEADBEEF}}};
    tbl[7] = '{1'b0, 32'd5, '0, {64{8'hA5}}};
    for (int i = 0; i < 8; i++) begin
      run_txn(tbl[i].is_wr, tbl[i].addr, tbl[i].wdata, 0, '0, got);
      if (!tbl[i].is_wr) check_line("tbl_rd", got, tbl[i].exp);
    end

    // Read and write together: read first, write accepted once IDLE again.
    idle(2);
    w = rnd_line(); exp1 = mem_m[1];
    address = 32'd1; write_data = w; read_request_valid = 1'b1; write_request_valid = 1'b1;
    for (int n = 1; n <= 11; n++) begin
      step();
      check_bits("both_pulses", 32'(pulses()), 32'({n == 1 || n == 7, n == 5, n == 9}));
      if (n == 5) check_line("both_rd", read_data, exp1);
      if (n == 1) begin read_request_valid = 1'b0; address = 32'd2; end
      if (n == 7) write_request_valid = 1'b0;
    end
    mem_m[2] = w; last_rd = exp1; in_resp = 1'b0;
    run_txn(1'b0, 32'd2, '0, 0, '0, got);
    check_line("both_wr", got, w);

    // Back-to-back reads issued right after each completion.
    idle(2);
    a0 = ack_cnt; d0 = dv_cnt; prev_done = 0;
    for (int i = 0; i < 8; i++) begin
      run_txn(1'b0, 32'(i), '0, 0, '0, got);
      if (i > 0) check_bits("b2b_spacing", 32'(last_done_cyc - prev_done), RL + 2);
      prev_done = last_done_cyc;
    end
    check_bits("b2b_acks", 32'(ack_cnt - a0), 8);
    check_bits("b2b_dvs", 32'(dv_cnt - d0), 8);

    // Host write on the read's RAM cycle: old data returned; request write beats host write.
    idle(2);
    old_l = mem_m[6]; new_l = rnd_line();
    run_txn(1'b0, 32'd6, '0, 2, new_l, got);
    check_line("rbw_old", got, old_l);
    run_txn(1'b0, 32'd6, '0, 0, '0, got);
    check_line("rbw_new", got, new_l);
    a_l = rnd_line(); b_l = rnd_line();
    run_txn(1'b1, 32'd8, a_l, 2, b_l, got);
    run_txn(1'b0, 32'd8, '0, 0, '0, got);
    check_line("req_wins", got, a_l);

    // Reset during a read: no completion afterwards, then normal operation.
    idle(2);
    address = 32'd4; read_request_valid = 1'b1;
    step();
    check_bits("rst_rd_ack", 32'(pulses()), 32'b100);
    read_request_valid = 1'b0;
    step();
    do_reset();
    #1;
    check_bits("rst_mid_pulses", 32'(pulses()), 0);
    check_line("rst_mid_rdata", read_data, '0);
    step(); step();
    rst_n = 1'b1;
    idle(8);
    run_txn(1'b0, 32'd4, '0, 0, '0, got);
    check_line("rst_recover", got, mem_m[4]);

    // Reset before a write commits: the line keeps its old contents.
    idle(2);
    old_l = mem_m[3];
    address = 32'd3; write_data = rnd_line(); write_request_valid = 1'b1;
    step();
    write_request_valid = 1'b0;
    step();
    do_reset();
    step();
    rst_n = 1'b1;
    idle(2);
    run_txn(1'b0, 32'd3, '0, 0, '0, got);
    check_line("wr_abort", got, old_l);

    // Addresses beyond DEPTH: wrap by default, flagged and suppressed with the range check.
    idle(2);
    run_txn(1'b0, DEPTH + 3, '0, 0, '0, got);
`ifdef MEM_RESP_RANGE_CHECK_EN
    check_line("oor_rd_zero", got, '0);
    check_bits("oor_flag", {15'd0, range_err, err_count}, {15'd0, 1'b1, 16'd1});
`else
    check_line("wrap_rd", got, mem_m[3]);
`endif
    old_l = mem_m[10]; new_l = rnd_line();
    run_txn(1'b1, DEPTH + 10, new_l, 0, '0, got);
    run_txn(1'b0, 32'd10, '0, 0, '0, got);
`ifdef MEM_RESP_RANGE_CHECK_EN
    check_line("oor_wr_blocked", got, old_l);
    check_bits("oor_count2", 32'(err_count), 2);
`else
    check_line("wrap_wr", got, new_l);
`endif

    // Random traffic with concurrent host writes.
    for (int i = 0; i < 60; i++) begin
      logic [31:0] a;
      a = 32'($urandom_range(15));
`ifndef MEM_RESP_RANGE_CHECK_EN
      a = a + 32'($urandom_range(3)) * DEPTH;
`endif
      if ($urandom_range(3) == 0) idle(int'($urandom_range(2)) + 1);
      run_txn(1'($urandom_range(1)), a, rnd_line(), 1, '0, got);
    end
    idle(3);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
